// File: rtl/rs_gen_pkg.sv
// Shared types and constants for the Reed-Solomon test-frame source:
// FSM states, pattern mode codes and the symbol-LFSR tap positions.
package rs_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_CNT  = 2'd0,
    MODE_LFSR = 2'd1,
    MODE_ZERO = 2'd2,
    MODE_ONES = 2'd3
  } mode_t;

  localparam int LFSR_STAGES = 8;
  localparam int LFSR_NTAPS  = 4;
  // Stage numbers (1-based) XORed into the new stage 8 on each advance.
  localparam int LFSR_TAPS [LFSR_NTAPS] = '{8, 6, 5, 4};

endpackage

// File: rtl/rs_sym_lfsr.sv
// Eight-stage, symbol-wide shift register. Stages shift toward stage 1;
// stage 8 takes the XOR of the tap stages. Load has priority over advance.
module rs_sym_lfsr
  import rs_gen_pkg::*;
#(
  parameter int unsigned                  SYM_W = 8,
  parameter logic [LFSR_STAGES*SYM_W-1:0] SEED  = '0
) (
  input  logic             clk_in,
  input  logic             sys_rst_n,
  input  logic             load_i,
  input  logic             adv_i,
  output logic [SYM_W-1:0] sym_o,
  output logic [SYM_W-1:0] sym_next_o
);

  typedef logic [LFSR_STAGES-1:0][SYM_W-1:0] stages_t;

  stages_t          stage_q, stage_d;
  logic [SYM_W-1:0] fb;

  // NOTE: every variable gets a default at the top of always_comb so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    fb      = '0;
    stage_d = stage_q;
    for (int i = 0; i < LFSR_STAGES; i++) begin
      for (int t = 0; t < LFSR_NTAPS; t++) begin
        if (LFSR_TAPS[t] == i + 1) fb = fb ^ stage_q[i];
      end
    end
    if (load_i) begin
      stage_d = stages_t'(SEED);
    end else if (adv_i) begin
      stage_d = {fb, stage_q[LFSR_STAGES-1:1]};
    end
  end

  // NOTE: the stage array is ordinary flops, not a RAM, so it takes the
  // async reset to the seed like any other state. Sequential state is
  // written with non-blocking assignments only.
  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stage_q <= stages_t'(SEED);
    end else begin
      stage_q <= stage_d;
    end
  end

  assign sym_o      = stage_q[0];
  assign sym_next_o = stage_q[1];

endmodule

// File: rtl/rs_frame_gen.sv
// RS test-frame source: K message symbols then an N-K cycle gap per frame,
// NUM_FRAMES frames per run. Define RS_FRAME_GEN_TAG_EN to tag symbol 1 with frame_idx.
module rs_frame_gen
  import rs_gen_pkg::*;
#(
  parameter int unsigned                  SYM_W      = 8,
  parameter int unsigned                  N          = 255,
  parameter int unsigned                  K          = 239,
  parameter int unsigned                  NUM_FRAMES = 64,
  parameter logic [LFSR_STAGES*SYM_W-1:0] LFSR_SEED  = 64'h6C29_5A7F_9AF0_D7E6
) (
  input  logic                               clk_in,
  input  logic                               sys_rst_n,
  input  logic                               start,
  input  logic [1:0]                         mode,
  input  logic                               out_ready,
  output logic [SYM_W-1:0]                   data_out,
  output logic                               data_valid,
  output logic                               sync,
  output logic [$clog2(NUM_FRAMES+1)-1:0]    frame_idx,
  output logic                               busy,
  output logic                               done
);

  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned FI_W  = $clog2(NUM_FRAMES + 1);

  localparam logic [CNT_W-1:0] SYM_FIRST = CNT_W'(1);
  localparam logic [CNT_W-1:0] SYM_LAST  = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(N - K - 1);
  localparam logic [FI_W-1:0]  FRAME_END = FI_W'(NUM_FRAMES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FI_W-1:0]  frame_q, frame_d;
  mode_t            mode_q, mode_d;
  logic [SYM_W-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             sync_q, sync_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             load_sym;
  logic             use_next;
  logic [CNT_W-1:0] sym_idx;
  mode_t            pat_mode;
  logic             lfsr_load;
  logic             lfsr_adv;
  logic [SYM_W-1:0] lfsr_sym;
  logic [SYM_W-1:0] lfsr_next;

  assign lfsr_load = !start || (state_q == ST_IDLE);

  rs_sym_lfsr #(
    .SYM_W (SYM_W),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk_in     (clk_in),
    .sys_rst_n  (sys_rst_n),
    .load_i     (lfsr_load),
    .adv_i      (lfsr_adv),
    .sym_o      (lfsr_sym),
    .sym_next_o (lfsr_next)
  );

  // The output register is loaded with the symbol that will be presented
  // next; on an accepting edge the LFSR has not shifted yet, so its
  // post-shift stage 1 (current stage 2) is used instead.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    frame_d  = frame_q;
    mode_d   = mode_q;
    dout_d   = dout_q;
    valid_d  = valid_q;
    sync_d   = sync_q;
    load_sym = 1'b0;
    use_next = 1'b0;
    sym_idx  = SYM_FIRST;
    pat_mode = mode_q;
    lfsr_adv = 1'b0;

    if (!start) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      frame_d = '0;
      dout_d  = '0;
      valid_d = 1'b0;
      sync_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_DATA;
          mode_d  = mode_t'(mode);
        end
        ST_DATA: begin
          if (!valid_q) begin
            load_sym = 1'b1;
            sym_idx  = cnt_q + 1'b1;
          end else if (out_ready) begin
            lfsr_adv = 1'b1;
            if (cnt_q == SYM_LAST) begin
              state_d = ST_GAP;
              cnt_d   = '0;
              dout_d  = '0;
              valid_d = 1'b0;
              sync_d  = 1'b0;
            end else begin
              cnt_d    = cnt_q + 1'b1;
              load_sym = 1'b1;
              use_next = 1'b1;
              sym_idx  = cnt_q + CNT_W'(2);
            end
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            frame_d = frame_q + 1'b1;
            if (frame_d == FRAME_END) begin
              state_d = ST_DONE;
            end else begin
              // Next frame's first symbol goes out on this same edge, so
              // the freshly sampled mode selects its pattern directly.
              state_d  = ST_DATA;
              mode_d   = mode_t'(mode);
              pat_mode = mode_t'(mode);
              load_sym = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (load_sym) begin
      case (pat_mode)
        MODE_CNT:  dout_d = SYM_W'(sym_idx);
        MODE_LFSR: dout_d = use_next ? lfsr_next : lfsr_sym;
        MODE_ZERO: dout_d = '0;
        default:   dout_d = '1;
      endcase
`ifdef RS_FRAME_GEN_TAG_EN
      if (sym_idx == SYM_FIRST) dout_d = SYM_W'(frame_d);
`else
`endif
      valid_d = 1'b1;
      sync_d  = (sym_idx == SYM_FIRST);
    end

    busy_d = (state_d == ST_DATA) || (state_d == ST_GAP);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
      mode_q  <= MODE_CNT;
      dout_q  <= '0;
      valid_q <= 1'b0;
      sync_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      mode_q  <= mode_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      sync_q  <= sync_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign sync       = sync_q;
  assign frame_idx  = frame_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_rs_frame_gen.sv
// Directed bench for rs_frame_gen: default 255/239/64 instance plus a
// small 15/11/2 instance with 4-bit symbols.
module tb_rs_frame_gen;

`ifdef RS_FRAME_GEN_TAG_EN
  localparam bit TAG = 1'b1;
`else
  localparam bit TAG = 1'b0;
`endif

  localparam int N1 = 255;
  localparam int K1 = 239;
  localparam int F1 = 64;

  logic       clk_in = 1'b0;
  logic       sys_rst_n;
  logic       start, out_ready;
  logic [1:0] mode;
  logic [7:0] data_out;
  logic       data_valid, sync, busy, done;
  logic [6:0] frame_idx;

  logic       start2, ready2;
  logic [1:0] mode2;
  logic [3:0] data_out2;
  logic       data_valid2, sync2, busy2, done2;
  logic [1:0] frame_idx2;

  always #5 clk_in = ~clk_in;

  rs_frame_gen dut (
    .clk_in     (clk_in),
    .sys_rst_n  (sys_rst_n),
    .start      (start),
    .mode       (mode),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .sync       (sync),
    .frame_idx  (frame_idx),
    .busy       (busy),
    .done       (done)
  );

  rs_frame_gen #(
    .SYM_W      (4),
    .N          (15),
    .K          (11),
    .NUM_FRAMES (2),
    .LFSR_SEED  (32'h9AF0_D7E6)
  ) dut2 (
    .clk_in     (clk_in),
    .sys_rst_n  (sys_rst_n),
    .start      (start2),
    .mode       (mode2),
    .out_ready  (ready2),
    .data_out   (data_out2),
    .data_valid (data_valid2),
    .sync       (sync2),
    .frame_idx  (frame_idx2),
    .busy       (busy2),
    .done       (done2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Reference LFSR: stages 1..8 in m[0..7], new stage 8 = s8^s6^s5^s4.
  logic [7:0] m [8];

  task automatic model_reset();
    logic [63:0] seed;
    seed = 64'h6C29_5A7F_9AF0_D7E6;
    for (int i = 0; i < 8; i++) m[i] = seed[8*i +: 8];
  endtask

  task automatic model_adv();
    logic [7:0] fb;
    fb = m[7] ^ m[5] ^ m[4] ^ m[3];
    for (int i = 0; i < 7; i++) m[i] = m[i+1];
    m[7] = fb;
  endtask

  typedef struct {
    logic       start;
    logic [1:0] mode;
    logic       rdy;
    logic [7:0] dout;
    logic       valid;
    logic       sync;
    logic [6:0] fidx;
    logic       busy;
    logic       done;
  } vec_t;

  function automatic vec_t mk(logic s, logic [1:0] md, logic r, logic [7:0] d,
                              logic v, logic sy, logic [6:0] fi, logic b, logic dn);
    vec_t x;
    x.start = s; x.mode = md; x.rdy = r; x.dout = d;
    x.valid = v; x.sync = sy; x.fidx = fi; x.busy = b; x.done = dn;
    return x;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       vecs [16];
    logic [7:0] first1;
    logic [7:0] exp8, hd;
    logic [3:0] exp4;
    logic       held, hs;
    int         nerr, nsync, acc, aerr, herr;

    first1 = TAG ? 8'h00 : 8'hE6;
    // Mode 1 from reset with stalls, mid-frame mode changes, abort, restart.
    vecs[0]  = mk(1, 2'd1, 1, 8'h00,  0, 0, 0, 1, 0);
    vecs[1]  = mk(1, 2'd1, 1, first1, 1, 1, 0, 1, 0);
    vecs[2]  = mk(1, 2'd1, 0, first1, 1, 1, 0, 1, 0);
    vecs[3]  = mk(1, 2'd1, 1, 8'hD7,  1, 0, 0, 1, 0);
    vecs[4]  = mk(1, 2'd1, 0, 8'hD7,  1, 0, 0, 1, 0);
    vecs[5]  = mk(1, 2'd0, 1, 8'hF0,  1, 0, 0, 1, 0);
    vecs[6]  = mk(1, 2'd0, 1, 8'h9A,  1, 0, 0, 1, 0);
    vecs[7]  = mk(1, 2'd0, 1, 8'h7F,  1, 0, 0, 1, 0);
    vecs[8]  = mk(1, 2'd0, 1, 8'h5A,  1, 0, 0, 1, 0);
    vecs[9]  = mk(1, 2'd1, 1, 8'h29,  1, 0, 0, 1, 0);
    vecs[10] = mk(1, 2'd1, 1, 8'h6C,  1, 0, 0, 1, 0);
    vecs[11] = mk(1, 2'd1, 1, 8'hD3,  1, 0, 0, 1, 0);
    vecs[12] = mk(1, 2'd1, 0, 8'hD3,  1, 0, 0, 1, 0);
    vecs[13] = mk(0, 2'd1, 1, 8'h00,  0, 0, 0, 0, 0);
    vecs[14] = mk(1, 2'd1, 1, 8'h00,  0, 0, 0, 1, 0);
    vecs[15] = mk(1, 2'd1, 1, first1, 1, 1, 0, 1, 0);

    sys_rst_n = 1'b0;
    start = 1'b0; mode = 2'd0; out_ready = 1'b1;
    start2 = 1'b0; mode2 = 2'd0; ready2 = 1'b1;
    #12;
    check("reset_dut", {data_out, data_valid, sync, frame_idx, busy, done}, '0);
    check("reset_dut2", {data_out2, data_valid2, sync2, frame_idx2, busy2, done2}, '0);
    sys_rst_n = 1'b1;
    step();

    for (int i = 0; i < 16; i++) begin
      start = vecs[i].start; mode = vecs[i].mode; out_ready = vecs[i].rdy;
      step();
      check($sformatf("vec%0d", i), {data_out, data_valid, sync, frame_idx, busy, done},
            {vecs[i].dout, vecs[i].valid, vecs[i].sync, vecs[i].fidx, vecs[i].busy, vecs[i].done});
    end

    // Full default run, counter pattern, ready held high.
    start = 1'b0; step();
    start = 1'b1; mode = 2'd0; out_ready = 1'b1; step();
    check("a_entry", {data_valid, busy}, 2'b01);
    nsync = 0;
    for (int f = 0; f < F1; f++) begin
      nerr = 0;
      for (int c = 0; c < N1; c++) begin
        step();
        if (c < K1) begin
          exp8 = (c == 0 && TAG) ? 8'(f) : 8'(c + 1);
          if (sync) nsync++;
          if (data_out !== exp8 || data_valid !== 1'b1 || sync !== (c == 0) ||
              frame_idx !== 7'(f) || busy !== 1'b1 || done !== 1'b0) nerr++;
        end else begin
          if (data_out !== 8'h00 || data_valid !== 1'b0 || sync !== 1'b0 ||
              frame_idx !== 7'(f) || busy !== 1'b1 || done !== 1'b0) nerr++;
        end
      end
      check($sformatf("a_frame%0d", f), nerr, 0);
    end
    check("a_sync_count", nsync, F1);
    step();
    check("a_done", {data_valid, frame_idx, busy, done}, {1'b0, 7'd64, 1'b0, 1'b1});
    step();
    check("a_done_hold", {frame_idx, done}, {7'd64, 1'b1});
    start = 1'b0; step();
    check("a_idle", {data_out, data_valid, sync, frame_idx, busy, done}, '0);

    // LFSR pattern across two frames, no reseed between frames.
    model_reset();
    start = 1'b1; mode = 2'd1; out_ready = 1'b1; step();
    for (int f = 0; f < 2; f++) begin
      nerr = 0;
      for (int c = 0; c < N1; c++) begin
        step();
        if (c < K1) begin
          exp8 = (c == 0 && TAG) ? 8'(f) : m[0];
          if (data_out !== exp8 || data_valid !== 1'b1 || frame_idx !== 7'(f)) nerr++;
          model_adv();
        end else begin
          if (data_out !== 8'h00 || data_valid !== 1'b0) nerr++;
        end
      end
      check($sformatf("b_lfsr_frame%0d", f), nerr, 0);
    end

    // Abort at symbol 100 of frame 3, then restart from a reseeded LFSR.
    start = 1'b0; step();
    model_reset();
    start = 1'b1; mode = 2'd1; out_ready = 1'b1; step();
    for (int s = 0; s < 3 * N1 + 100; s++) step();
    for (int s = 0; s < 3 * K1 + 99; s++) model_adv();
    check("d_sym100", {data_out, data_valid, sync, frame_idx}, {m[0], 1'b1, 1'b0, 7'd3});
    start = 1'b0; step();
    check("d_abort", {data_out, data_valid, sync, frame_idx, busy, done}, '0);
    start = 1'b1; step(); step();
    check("d_restart", {data_out, data_valid, sync, frame_idx, busy, done},
          {first1, 1'b1, 1'b1, 7'd0, 1'b1, 1'b0});

    // Ready toggling 1,0 through frame 0.
    start = 1'b0; step();
    start = 1'b1; mode = 2'd0; out_ready = 1'b1; step();
    acc = 0; aerr = 0; herr = 0;
    for (int cyc = 0; cyc < 1000 && acc < K1; cyc++) begin
      out_ready = (cyc % 2 == 0);
      if (data_valid && out_ready) begin
        exp8 = (acc == 0 && TAG) ? 8'h00 : 8'(acc + 1);
        if (data_out !== exp8 || sync !== (acc == 0)) aerr++;
        acc++;
      end
      held = data_valid && !out_ready;
      hd = data_out;
      hs = sync;
      step();
      if (held && (data_out !== hd || sync !== hs || data_valid !== 1'b1)) herr++;
    end
    check("c_accepted", acc, K1);
    check("c_order", aerr, 0);
    check("c_hold", herr, 0);
    check("c_gap", {data_valid, busy}, 2'b01);
    start = 1'b0; out_ready = 1'b1; step();

    // Small instance, all-ones, with a mid-frame mode wiggle that must be ignored.
    start2 = 1'b1; mode2 = 2'd3; ready2 = 1'b1; step();
    nerr = 0;
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 15; c++) begin
        if (f == 0 && c == 2) mode2 = 2'd2;
        if (f == 0 && c == 6) mode2 = 2'd3;
        step();
        if (c < 11) begin
          exp4 = (c == 0 && TAG) ? 4'(f) : 4'hF;
          if (data_out2 !== exp4 || data_valid2 !== 1'b1 || sync2 !== (c == 0) ||
              frame_idx2 !== 2'(f) || busy2 !== 1'b1 || done2 !== 1'b0) nerr++;
        end else begin
          if (data_out2 !== 4'h0 || data_valid2 !== 1'b0 || frame_idx2 !== 2'(f) ||
              busy2 !== 1'b1 || done2 !== 1'b0) nerr++;
        end
      end
    end
    check("e_frames", nerr, 0);
    step();
    check("e_done", {done2, frame_idx2, data_valid2, busy2}, {1'b1, 2'd2, 1'b0, 1'b0});
    start2 = 1'b0; step();
    check("e_idle", {done2, frame_idx2, busy2}, '0);
    start2 = 1'b1; mode2 = 2'd2; step(); step();
    check("e_zero_first", {data_out2, data_valid2, sync2}, {4'h0, 1'b1, 1'b1});
    step();
    check("e_zero_second", {data_out2, data_valid2, sync2}, {4'h0, 1'b1, 1'b0});
    start2 = 1'b0; step();

    // Asynchronous reset mid-frame clears outputs without a clock edge.
    start = 1'b1; mode = 2'd0; out_ready = 1'b1; step(); step(); step();
    check("f_running", {data_valid, busy}, 2'b11);
    #3 sys_rst_n = 1'b0;
    #1;
    check("f_async_reset", {data_out, data_valid, sync, frame_idx, busy, done}, '0);
    start = 1'b0;
    #2 sys_rst_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rs_frame_gen.md
# rs_frame_gen

Parametrised Reed-Solomon test-frame source for the decoder bench and on-board self-test. It emits bursts of K message symbols, each followed by an N−K-cycle parity gap, for a programmed number of frames. Symbols are drawn from a selectable pattern: counter, symbol-wide LFSR, all-zero or all-ones. A downstream ready input can stall the burst. It sits ahead of the RS encoder/channel model and feeds the decoder under test.

## Interface
- SYM_W, 8, symbol width in bits
- N, 255, codeword length in symbols; N ≤ 2^SYM_W − 1
- K, 239, message symbols per frame; 1 ≤ K < N
- NUM_FRAMES, 64, frames per run; ≥ 1
- LFSR_SEED, 64'h6C29_5A7F_9AF0_D7E6, 8×SYM_W-bit seed; stage 8 in the MSBs, stage 1 in the LSBs
- clk_in  in  1  clock
- sys_rst_n  in  1  asynchronous, active-low reset
- start  in  1  level run enable; low aborts the run and returns to idle
- mode  in  2  pattern select: 0 counter, 1 LFSR, 2 all-zero, 3 all-ones; sampled at frame start only
- out_ready  in  1  downstream accepts the current symbol
- data_out  out  SYM_W  current symbol
- data_valid  out  1  high while data_out holds a message symbol
- sync  out  1  one-cycle pulse with the first symbol of each frame
- frame_idx  out  clog2(NUM_FRAMES+1)  completed-frame count
- busy  out  1  high in DATA or GAP
- done  out  1  high in DONE

## Operation
- FSM states: IDLE, DATA, GAP, DONE.
- IDLE:
  - Symbol counter = 0, frame_idx = 0, LFSR loaded with LFSR_SEED.
  - start=1 → DATA, with mode latched.
- DATA:
  - A symbol is accepted on a cycle where data_valid && out_ready.
  - On acceptance, the symbol counter and the LFSR advance.
  - When the K-th symbol is accepted → GAP.
  - out_ready=0 holds data_out, data_valid and sync stable.
- GAP:
  - data_valid=0 and data_out=0.
  - Counts exactly N−K cycles, independent of out_ready.
  - At the end: frame_idx+1; if the new value equals NUM_FRAMES → DONE, else → DATA, with mode re-latched.
- DONE: data_valid=0, data_out=0, done=1; stays until start=0, then → IDLE.
- start=0 in any state → IDLE on the next edge. All counters reset and the LFSR is reseeded, so the next run restarts at frame 0.
- Pattern for message symbol i (i = 1..K):
  - Counter: i mod 2^SYM_W.
  - LFSR: stage 1. Feedback = s8^s6^s5^s4, shifting toward s1. The LFSR is not reseeded between frames.
  - All-zero: 0.
  - All-ones: 2^SYM_W − 1.
- Symbol counter width: clog2(N+1); it wraps to 0 at frame end.

## Timing
- Reset values: data_out=0, data_valid=0, sync=0, frame_idx=0, busy=0, done=0; state IDLE.
- All outputs are registered.
- start sampled high at edge t → first symbol, data_valid=1 and sync=1 are visible after edge t+1.
- With out_ready held high, one frame takes exactly N cycles: K valid followed by N−K idle.
- sync is high only while the first symbol of a frame is presented. If that symbol is stalled, sync stays high until it is accepted, then drops.
- The last accepted symbol is followed by the next edge entering GAP, with data_valid=0.
- frame_idx increments on the edge that leaves GAP; done rises on that same edge for the final frame.
- Asynchronous reset mid-frame takes effect immediately; there is no partial-frame recovery.

## Configuration
- RS_FRAME_GEN_TAG_EN:
  - Defined: the first message symbol of every frame is replaced by frame_idx, truncated or zero-extended to SYM_W. All other symbols, and the LFSR sequence, are unchanged; the LFSR still advances on the tag symbol.
  - Undefined: no substitution.

## Structure
- Package rs_gen_pkg: FSM state enum, mode codes (MODE_CNT, MODE_LFSR, MODE_ZERO, MODE_ONES), tap positions {8,6,5,4}.
- Sub-module rs_sym_lfsr: 8-stage SYM_W-wide shift register with load (seed) and advance enables; output is stage 1.

## Test plan
- Defaults, mode 0, out_ready=1, start held → 64 frames of symbols 1..239, each followed by 16 invalid cycles. sync is seen 64 times; done rises after 64×255 cycles.
- Mode 1 → the first symbols of frame 0 equal seed stages 1..8 (E6, D7, F0, 9A, 7F, 5A, 29, 6C). Symbol 9 = 6C^5A^7F^9A. Frame 1 continues the sequence without reseeding.
- out_ready toggled 1,0 repeatedly in DATA → data_out is held across stalls, K symbols are still accepted in order, and sync does not repeat.
- start dropped at symbol 100 of frame 3, then reasserted → restart at frame_idx=0, symbol 1, with a reseeded LFSR.
- N=15, K=11, SYM_W=4, NUM_FRAMES=2, mode 3 → two frames of 11 × 4'hF plus 4 gap cycles each; done=1; frame_idx=2.
- With RS_FRAME_GEN_TAG_EN, mode 0 → the first symbol of frames 0..3 reads 0, 1, 2, 3, and the rest of each frame is 2..239.
